// File: rtl/icache_dm_if.sv
// Word-read bus between the instruction cache and its backing memory.
// The cache drives req/addr and the memory answers with ack/rdata in the same cycle it accepts.
interface icache_dm_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with same-cycle hits and whole-line refill.
// Refill runs word 0 upward over a req/ack bus; a flush during a refill leaves that line invalid.
module icache_dm #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    output logic [31:0]        instr,
    output logic               stall,
    input  logic               flush,
    icache_dm_if.master        mem,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    logic [31:0]        data_q [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]   tag_q  [LINES];

    logic               data_we;
    logic               tag_we;

    logic [OFF_W-1:0]   pc_off;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic               hit;
    logic               last_word;
    logic [OFF_W-1:0]   cnt_next;
    logic               unused_pc_bits;

    assign pc_off = pc[OFF_W+1:2];
    assign pc_idx = pc[OFF_W+IDX_W+1:OFF_W+2];
    assign pc_tag = pc[31:OFF_W+IDX_W+2];
    assign unused_pc_bits = ^pc[1:0];

    assign hit       = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign stall     = ~hit;
    assign instr     = hit ? data_q[{pc_idx, pc_off}] : 32'h0000_0000;
    assign last_word = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
    assign cnt_next  = cnt_q + OFF_W'(1);

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end
                if (hit) begin
                    if (hit_cnt_q != 32'hFFFF_FFFF) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end
                end else begin
                    miss_tag_d = pc_tag;
                    miss_idx_d = pc_idx;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_tag, pc_idx, {OFF_W{1'b0}}, 2'b00};
                    state_d    = FILL;
                    if (miss_cnt_q != 32'hFFFF_FFFF) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                end
            end
            FILL: begin
                if (flush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b1;
                end
                if (mem.mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_next;
                    if (last_word) begin
                        // A flush arriving with the final ack still counts as pending.
                        tag_we              = 1'b1;
                        valid_d[miss_idx_q] = ~(flush_pend_q | flush);
                        flush_pend_d        = 1'b0;
                        mem_req_d           = 1'b0;
                        state_d             = IDLE;
                    end else begin
                        mem_addr_d = {miss_tag_q, miss_idx_q, cnt_next, 2'b00};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Storage arrays carry no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (!reset && data_we) begin
            data_q[{miss_idx_q, cnt_q}] <= mem.mem_rdata;
        end
        if (!reset && tag_we) begin
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: stimulus queues expected instructions and memory
// addresses, a negedge monitor pops them whenever the cache returns a hit or accepts a word.
module tb_icache_dm;
    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int          wait_cycles;
    int          wcnt;
    int          pass_cnt;
    int          total_cnt;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_addr_q[$];

    icache_dm_if bus();

    icache_dm #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .instr    (instr),
        .stall    (stall),
        .flush    (flush),
        .mem      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: word i holds 0x1000+i, acks after wait_cycles idle cycles.
    assign bus.mem_ack   = bus.mem_req && (wcnt == wait_cycles);
    assign bus.mem_rdata = 32'h0000_1000 + (bus.mem_addr >> 2);

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (!stall) begin
                if (exp_instr_q.size() == 0) begin
                    total_cnt++;
                    $display("[TB] FAIL unexpected_hit: got instr %h with no expected entry", instr);
                end else begin
                    check_output("instr", instr, exp_instr_q.pop_front());
                end
            end
            if (bus.mem_req && bus.mem_ack) begin
                if (exp_addr_q.size() == 0) begin
                    total_cnt++;
                    $display("[TB] FAIL unexpected_req: got mem_addr %h with no expected entry", bus.mem_addr);
                end else begin
                    check_output("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
                end
            end
        end
    end

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        pc    = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Present addr and count stall cycles until the hit; hold counts cycles the line base is requested.
    task automatic apply_stimulus(input logic [31:0] addr, input int exp_stall, input int exp_hold);
        int stalls = 0;
        int hold   = 0;
        pc = addr;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (bus.mem_req && bus.mem_addr == {addr[31:4], 4'h0}) hold++;
            if (stalls > 200) begin
                $display("[TB] FAIL fetch_timeout: got %0d stall cycles expected %0d", stalls, exp_stall);
                break;
            end
        end
        check_output("stall_cycles", 32'(stalls), 32'(exp_stall));
        if (exp_hold >= 0) check_output("addr_hold", 32'(hold), 32'(exp_hold));
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        wait_cycles = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        pc          = 32'h0;
        do_reset();

        check_output("reset_stall", 32'(stall), 32'd1);
        check_output("reset_mem_req", 32'(bus.mem_req), 32'd0);
        check_output("reset_instr", instr, 32'h0);
        check_output("reset_hit_cnt", hit_cnt, 32'd0);
        check_output("reset_miss_cnt", miss_cnt, 32'd0);

        // Zero-wait cold miss then three hits in the same line.
        push_line(32'h0);
        exp_instr_q.push_back(32'h1000);
        apply_stimulus(32'h0, 5, 1);
        exp_instr_q.push_back(32'h1001);
        apply_stimulus(32'h4, 0, -1);
        exp_instr_q.push_back(32'h1002);
        apply_stimulus(32'h8, 0, -1);
        exp_instr_q.push_back(32'h1003);
        apply_stimulus(32'hC, 0, -1);
        check_output("hit_cnt_t1", hit_cnt, 32'd4);
        check_output("miss_cnt_t1", miss_cnt, 32'd1);

        // Two wait states per word.
        wait_cycles = 2;
        push_line(32'h20);
        exp_instr_q.push_back(32'h1008);
        apply_stimulus(32'h20, 13, 3);
        wait_cycles = 0;
        exp_instr_q.push_back(32'h100B);
        apply_stimulus(32'h2C, 0, -1);
        check_output("miss_cnt_t2", miss_cnt, 32'd2);

        // Conflict misses on index 0.
        do_reset();
        push_line(32'h0);
        exp_instr_q.push_back(32'h1000);
        apply_stimulus(32'h0, 5, 1);
        push_line(32'h100);
        exp_instr_q.push_back(32'h1040);
        apply_stimulus(32'h100, 5, 1);
        push_line(32'h0);
        exp_instr_q.push_back(32'h1000);
        apply_stimulus(32'h0, 5, 1);
        check_output("miss_cnt_t3", miss_cnt, 32'd3);

        // Flush in IDLE: the flush cycle still hits, the next access misses.
        exp_instr_q.push_back(32'h1000);
        flush = 1'b1;
        @(negedge clk);
        check_output("flush_cycle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        check_output("post_flush_stall", 32'(stall), 32'd1);
        push_line(32'h0);
        exp_instr_q.push_back(32'h1000);
        apply_stimulus(32'h0, 5, 1);
        check_output("miss_cnt_t4", miss_cnt, 32'd4);

        // Flush during the second word of a fill: the line is refilled twice.
        do_reset();
        push_line(32'h40);
        push_line(32'h40);
        exp_instr_q.push_back(32'h1010);
        fork
            apply_stimulus(32'h40, 10, 2);
            begin
                repeat (2) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        check_output("miss_cnt_t5", miss_cnt, 32'd2);
        check_output("hit_cnt_t5", hit_cnt, 32'd1);

        // Reset in FILL after the second ack.
        do_reset();
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_output("rst_fill_mem_req", 32'(bus.mem_req), 32'd0);
        check_output("rst_fill_hit_cnt", hit_cnt, 32'd0);
        check_output("rst_fill_miss_cnt", miss_cnt, 32'd0);
        check_output("rst_fill_stall", 32'(stall), 32'd1);
        push_line(32'h0);
        exp_instr_q.push_back(32'h1000);
        apply_stimulus(32'h0, 5, 1);
        check_output("miss_cnt_t6", miss_cnt, 32'd1);

        check_output("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);
        check_output("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
